// File: rtl/vending_ctrl_multi.sv
// Multi-product vending controller: coin credit accumulator, per-item
// pricing, inactivity refund, drop-sensor supervised vend, and coin-by-coin
// change payout. Single clock; `tick` is a slow enable from the divider.
module vending_ctrl_multi #(
    parameter int                          N_ITEMS        = 4,
    parameter int                          CREDIT_W       = 8,
    parameter logic [N_ITEMS*CREDIT_W-1:0] PRICE_LIST     = {8'd3, 8'd2, 8'd2, 8'd1},
    parameter int                          MAX_CREDIT     = 15,
    parameter int                          TIMEOUT_TICKS  = 50,
    parameter int                          DISPENSE_TICKS = 10
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         tick,
    input  logic                         coin_valid,
    input  logic [1:0]                   coin_value,
    input  logic                         sel_valid,
    input  logic [$clog2(N_ITEMS)-1:0]   sel_idx,
    input  logic                         cancel,
    input  logic                         item_sensor,
    output logic [CREDIT_W-1:0]          credit,
    output logic [N_ITEMS-1:0]           dispense,
    output logic                         change_pulse,
    output logic                         coin_reject,
    output logic                         insufficient,
    output logic                         vend_fault,
    output logic                         busy
);

    localparam int IDX_W = $clog2(N_ITEMS);
    localparam int TMO_W = $clog2(TIMEOUT_TICKS + 1);
    localparam int DSP_W = $clog2(DISPENSE_TICKS + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CREDIT = 2'd1;
    localparam logic [1:0] ST_VEND   = 2'd2;
    localparam logic [1:0] ST_CHANGE = 2'd3;

    localparam logic [CREDIT_W:0]   MAX_C     = MAX_CREDIT[CREDIT_W:0];
    localparam logic [TMO_W-1:0]    TMO_LIMIT = TIMEOUT_TICKS[TMO_W-1:0];
    localparam logic [DSP_W-1:0]    DSP_LIMIT = DISPENSE_TICKS[DSP_W-1:0];
    localparam logic [CREDIT_W-1:0] CREDIT_ONE = {{(CREDIT_W-1){1'b0}}, 1'b1};

    // Coin code to credit units, widened by one bit so sums never wrap.
    function automatic logic [CREDIT_W:0] coin_units(input logic [1:0] code);
        logic [CREDIT_W:0] units;
        units = '0;
        case (code)
            2'b01:   units[2:0] = 3'd1;
            2'b10:   units[2:0] = 3'd2;
            2'b11:   units[2:0] = 3'd5;
            default: units[2:0] = 3'd0;
        endcase
        return units;
    endfunction

    // Price of one product; out-of-range indices read as zero.
    function automatic logic [CREDIT_W-1:0] price_of(input logic [IDX_W-1:0] idx);
        logic [CREDIT_W-1:0] p;
        if (int'(idx) < N_ITEMS) begin
            p = PRICE_LIST[int'(idx)*CREDIT_W +: CREDIT_W];
        end else begin
            p = '0;
        end
        return p;
    endfunction

    logic [1:0]          state_q,   state_d;
    logic [CREDIT_W-1:0] credit_q,  credit_d;
    logic [N_ITEMS-1:0]  disp_q,    disp_d;
    logic [IDX_W-1:0]    vidx_q,    vidx_d;
    logic [TMO_W-1:0]    tmo_q,     tmo_d;
    logic [DSP_W-1:0]    vcnt_q,    vcnt_d;
    logic                chg_q,     chg_d;
    logic                rej_q,     rej_d;
    logic                ins_q,     ins_d;
    logic                flt_q,     flt_d;
    logic                busy_q,    busy_d;

    logic                coin_present_s;
    logic [CREDIT_W:0]   coin_sum_s;
    logic [CREDIT_W-1:0] sel_price_s;
    logic [TMO_W-1:0]    tmo_inc_s;
    logic [DSP_W-1:0]    vcnt_inc_s;
    logic                sel_ok_s;

    assign coin_present_s = coin_valid && (coin_value != 2'b00);
    assign coin_sum_s     = {1'b0, credit_q} + coin_units(coin_value);
    assign sel_price_s    = price_of(sel_idx);
    assign tmo_inc_s      = tmo_q + {{(TMO_W-1){1'b0}}, tick};
    assign vcnt_inc_s     = vcnt_q + {{(DSP_W-1){1'b0}}, tick};
    assign sel_ok_s       = sel_valid && (int'(sel_idx) < N_ITEMS);

    // Next-state and next-output decision for every state.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        disp_d   = disp_q;
        vidx_d   = vidx_q;
        tmo_d    = tmo_q;
        vcnt_d   = vcnt_q;
        chg_d    = 1'b0;
        rej_d    = 1'b0;
        ins_d    = 1'b0;
        flt_d    = 1'b0;
        case (state_q)
            ST_IDLE, ST_CREDIT: begin
                if (cancel || ((state_q == ST_CREDIT) && (tmo_inc_s >= TMO_LIMIT))) begin
                    // Cancel/timeout beats a coin arriving in the same cycle.
                    rej_d = coin_present_s;
                    tmo_d = '0;
                    if (state_q == ST_CREDIT) begin
                        state_d = ST_CHANGE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (coin_present_s) begin
                    if (coin_sum_s <= MAX_C) begin
                        credit_d = coin_sum_s[CREDIT_W-1:0];
                        state_d  = ST_CREDIT;
                        tmo_d    = '0;
                    end else begin
                        rej_d = 1'b1;
                        tmo_d = (state_q == ST_CREDIT) ? tmo_inc_s : '0;
                    end
                end else if (sel_ok_s && (state_q == ST_CREDIT)) begin
                    tmo_d = '0;
                    if ({1'b0, credit_q} >= {1'b0, sel_price_s}) begin
                        credit_d        = credit_q - sel_price_s;
                        disp_d          = '0;
                        disp_d[sel_idx] = 1'b1;
                        vidx_d          = sel_idx;
                        vcnt_d          = '0;
                        state_d         = ST_VEND;
                    end else begin
                        ins_d = 1'b1;
                    end
                end else begin
                    tmo_d = (state_q == ST_CREDIT) ? tmo_inc_s : '0;
                end
            end
            ST_VEND: begin
                rej_d = coin_present_s;
                if (item_sensor) begin
                    // Sensor wins a tie with the fault timer.
                    disp_d  = '0;
                    vcnt_d  = '0;
                    state_d = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
                end else if (vcnt_inc_s >= DSP_LIMIT) begin
                    disp_d   = '0;
                    vcnt_d   = '0;
                    flt_d    = 1'b1;
                    credit_d = credit_q + price_of(vidx_q);
                    state_d  = ST_CHANGE;
                end else begin
                    vcnt_d = vcnt_inc_s;
                end
            end
            ST_CHANGE: begin
                rej_d = coin_present_s;
                if (credit_q == '0) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    chg_d    = 1'b1;
                    credit_d = credit_q - CREDIT_ONE;
                    state_d  = (credit_q == CREDIT_ONE) ? ST_IDLE : ST_CHANGE;
                end else begin
                    state_d = ST_CHANGE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                credit_d = '0;
                disp_d   = '0;
                tmo_d    = '0;
                vcnt_d   = '0;
            end
        endcase
        busy_d = (state_d == ST_VEND) || (state_d == ST_CHANGE);
    end

    // State and registered outputs; reset drops any held credit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            credit_q <= '0;
            disp_q   <= '0;
            vidx_q   <= '0;
            tmo_q    <= '0;
            vcnt_q   <= '0;
            chg_q    <= 1'b0;
            rej_q    <= 1'b0;
            ins_q    <= 1'b0;
            flt_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            disp_q   <= disp_d;
            vidx_q   <= vidx_d;
            tmo_q    <= tmo_d;
            vcnt_q   <= vcnt_d;
            chg_q    <= chg_d;
            rej_q    <= rej_d;
            ins_q    <= ins_d;
            flt_q    <= flt_d;
            busy_q   <= busy_d;
        end
    end

    assign credit       = credit_q;
    assign dispense     = disp_q;
    assign change_pulse = chg_q;
    assign coin_reject  = rej_q;
    assign insufficient = ins_q;
    assign vend_fault   = flt_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_vending_ctrl_multi.sv
// Table-driven bench for vending_ctrl_multi: each record is one clock of
// inputs plus the outputs expected just after that clock edge.
module tb_vending_ctrl_multi;

    logic       CLK = 1'b0;
    logic       RST, tick, coin_valid, sel_valid, cancel, item_sensor;
    logic [1:0] coin_value, sel_idx;
    logic [7:0] credit;
    logic [3:0] dispense;
    logic       change_pulse, coin_reject, insufficient, vend_fault, busy;

    int n_assert = 0;
    int n_fail   = 0;

    vending_ctrl_multi dut (
        .CLK(CLK), .RST(RST), .tick(tick), .coin_valid(coin_valid),
        .coin_value(coin_value), .sel_valid(sel_valid), .sel_idx(sel_idx),
        .cancel(cancel), .item_sensor(item_sensor), .credit(credit),
        .dispense(dispense), .change_pulse(change_pulse),
        .coin_reject(coin_reject), .insufficient(insufficient),
        .vend_fault(vend_fault), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string      name;
        bit         r, t, cv, sv, ca, se;
        bit [1:0]   cval, si;
        bit [7:0]   e_credit;
        bit [3:0]   e_disp;
        bit         e_chg, e_rej, e_ins, e_flt, e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string nm, bit r, bit t, bit cv, bit [1:0] cval,
                                bit sv, bit [1:0] si, bit ca, bit se, int cr,
                                bit [3:0] d, bit chg, bit rej, bit ins, bit flt, bit bsy);
        vec_t v;
        v.name = nm; v.r = r; v.t = t; v.cv = cv; v.cval = cval; v.sv = sv;
        v.si = si; v.ca = ca; v.se = se; v.e_credit = cr[7:0]; v.e_disp = d;
        v.e_chg = chg; v.e_rej = rej; v.e_ins = ins; v.e_flt = flt; v.e_busy = bsy;
        return v;
    endfunction

    task automatic add(string nm, bit r, bit t, bit cv, bit [1:0] cval, bit sv,
                       bit [1:0] si, bit ca, bit se, int cr, bit [3:0] d,
                       bit chg, bit rej, bit ins, bit flt, bit bsy);
        vecs.push_back(mk(nm, r, t, cv, cval, sv, si, ca, se, cr, d, chg, rej, ins, flt, bsy));
    endtask

    // Drive one cycle of inputs, let the edge pass, then compare all outputs.
    task automatic apply(vec_t v);
        logic [16:0] got, exp;
        RST = v.r; tick = v.t; coin_valid = v.cv; coin_value = v.cval;
        sel_valid = v.sv; sel_idx = v.si; cancel = v.ca; item_sensor = v.se;
        @(posedge CLK);
        #1;
        got = {credit, dispense, change_pulse, coin_reject, insufficient, vend_fault, busy};
        exp = {v.e_credit, v.e_disp, v.e_chg, v.e_rej, v.e_ins, v.e_flt, v.e_busy};
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got credit=%0d disp=%b chg=%b rej=%b ins=%b flt=%b busy=%b; expected credit=%0d disp=%b chg=%b rej=%b ins=%b flt=%b busy=%b",
                     v.name, credit, dispense, change_pulse, coin_reject, insufficient, vend_fault, busy,
                     v.e_credit, v.e_disp, v.e_chg, v.e_rej, v.e_ins, v.e_flt, v.e_busy);
        end
    endtask

    task automatic step(string nm, bit t, bit cv, bit [1:0] cval, bit sv, bit [1:0] si,
                        bit se, int cr, bit [3:0] d, bit flt, bit bsy);
        apply(mk(nm, 1'b0, t, cv, cval, sv, si, 1'b0, se, cr, d, 1'b0, 1'b0, 1'b0, flt, bsy));
    endtask

    initial begin
        //   name        r t cv cval sv si ca se | credit disp chg rej ins flt busy
        add("reset",     1,0,0, 0,   0, 0, 0, 0,   0, 4'b0000, 0,0,0,0,0);
        add("reset2",    1,0,0, 0,   0, 0, 0, 0,   0, 4'b0000, 0,0,0,0,0);
        add("coin2",     0,0,1, 2,   0, 0, 0, 0,   2, 4'b0000, 0,0,0,0,0);
        add("coin5",     0,0,1, 3,   0, 0, 0, 0,   7, 4'b0000, 0,0,0,0,0);
        add("sel3",      0,0,0, 0,   1, 3, 0, 0,   4, 4'b1000, 0,0,0,0,1);
        add("vend_t1",   0,1,0, 0,   0, 0, 0, 0,   4, 4'b1000, 0,0,0,0,1);
        add("vend_t2",   0,1,0, 0,   0, 0, 0, 0,   4, 4'b1000, 0,0,0,0,1);
        add("sensor",    0,0,0, 0,   0, 0, 0, 1,   4, 4'b0000, 0,0,0,0,1);
        for (int i = 0; i < 4; i++)
            add("change4", 0,1,0,0,  0, 0, 0, 0,   3-i, 4'b0000, 1,0,0,0, i < 3);
        add("idle0",     0,0,0, 0,   0, 0, 0, 0,   0, 4'b0000, 0,0,0,0,0);
        add("coin1",     0,0,1, 1,   0, 0, 0, 0,   1, 4'b0000, 0,0,0,0,0);
        add("insuff",    0,0,0, 0,   1, 2, 0, 0,   1, 4'b0000, 0,0,1,0,0);
        add("coin_sel",  0,0,1, 1,   1, 0, 0, 0,   2, 4'b0000, 0,0,0,0,0);
        add("no_disp",   0,0,0, 0,   0, 0, 0, 0,   2, 4'b0000, 0,0,0,0,0);
        add("to7",       0,0,1, 3,   0, 0, 0, 0,   7, 4'b0000, 0,0,0,0,0);
        add("to12",      0,0,1, 3,   0, 0, 0, 0,  12, 4'b0000, 0,0,0,0,0);
        add("to13",      0,0,1, 1,   0, 0, 0, 0,  13, 4'b0000, 0,0,0,0,0);
        add("overflow",  0,0,1, 3,   0, 0, 0, 0,  13, 4'b0000, 0,1,0,0,0);
        add("cancel",    0,0,0, 0,   0, 0, 1, 0,  13, 4'b0000, 0,0,0,0,1);
        add("chg_coin",  0,1,1, 1,   0, 0, 0, 0,  12, 4'b0000, 1,1,0,0,1);
        for (int i = 0; i < 12; i++)
            add("change13", 0,1,0,0, 0, 0, 0, 0,  11-i, 4'b0000, 1,0,0,0, i < 11);
        add("f_coin2",   0,0,1, 2,   0, 0, 0, 0,   2, 4'b0000, 0,0,0,0,0);
        add("f_coin1",   0,0,1, 1,   0, 0, 0, 0,   3, 4'b0000, 0,0,0,0,0);
        add("f_sel0",    0,0,0, 0,   1, 0, 0, 0,   2, 4'b0001, 0,0,0,0,1);
        for (int i = 0; i < 9; i++)
            add("f_wait",  0,1,0,0,  0, 0, i == 4, 0, 2, 4'b0001, 0,0,0,0,1);
        add("fault",     0,1,0, 0,   0, 0, 0, 0,   3, 4'b0000, 0,0,0,1,1);
        for (int i = 0; i < 3; i++)
            add("f_change", 0,1,0,0, 0, 0, 0, 0,  2-i, 4'b0000, 1,0,0,0, i < 2);
        add("t_coin2",   0,0,1, 2,   0, 0, 0, 0,   2, 4'b0000, 0,0,0,0,0);
        for (int i = 0; i < 49; i++)
            add("t_wait",  0,1,0,0,  0, 0, 0, 0,   2, 4'b0000, 0,0,0,0,0);
        add("timeout",   0,1,0, 0,   0, 0, 0, 0,   2, 4'b0000, 0,0,0,0,1);
        add("t_change",  0,1,0, 0,   0, 0, 0, 0,   1, 4'b0000, 1,0,0,0,1);
        add("rst_mid",   1,1,0, 0,   0, 0, 0, 0,   0, 4'b0000, 0,0,0,0,0);
        add("post_rst",  0,1,0, 0,   0, 0, 0, 0,   0, 4'b0000, 0,0,0,0,0);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // Selection while IDLE is ignored.
        step("idle_sel", 0,0,0, 1,1, 0,   0, 4'b0000, 0, 0);
        // Sensor and fault timer expire together: sensor wins, credit 0 -> IDLE.
        step("tie_coin", 0,1,1, 0,0, 0,   1, 4'b0000, 0, 0);
        step("tie_sel",  0,0,0, 1,0, 0,   0, 4'b0001, 0, 1);
        for (int i = 0; i < 9; i++)
            step("tie_wait", 1,0,0, 0,0, 0, 0, 4'b0001, 0, 1);
        step("tie_both", 1,0,0, 0,0, 1,   0, 4'b0000, 0, 0);
        step("tie_after",0,1,2, 0,0, 0,   2, 4'b0000, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
